// File: rtl/ram64x18_pkg.sv
// Shared constants and lane helpers for the 64x18 RAM.
// Narrow lanes index a 16-bit view that skips the two ninth bits of the row.
package ram64x18_pkg;

    localparam int unsigned ROWS  = 64;
    localparam int unsigned ROW_W = 18;

    localparam logic [2:0] WIDTH_X1  = 3'b000;
    localparam logic [2:0] WIDTH_X2  = 3'b001;
    localparam logic [2:0] WIDTH_X4  = 3'b010;
    localparam logic [2:0] WIDTH_X9  = 3'b011;
    localparam logic [2:0] WIDTH_X18 = 3'b100;

    function automatic logic [ROW_W-1:0] view_to_row(input logic [15:0] v);
        return {1'b0, v[15:8], 1'b0, v[7:0]};
    endfunction

    // Right-justified lane extraction; codes above x18 behave as x18.
    function automatic logic [ROW_W-1:0] lane_read(input logic [ROW_W-1:0] row,
                                                  input logic [3:0] sel,
                                                  input logic [2:0] width);
        logic [15:0]      view;
        logic [ROW_W-1:0] r;
        view = {row[16:9], row[7:0]};
        case (width)
            WIDTH_X1: r = {17'b0, view[sel]};
            WIDTH_X2: r = {16'b0, view[{sel[3:1], 1'b0} +: 2]};
            WIDTH_X4: r = {14'b0, view[{sel[3:2], 2'b00} +: 4]};
            WIDTH_X9: r = sel[3] ? {9'b0, row[17:9]} : {9'b0, row[8:0]};
            default:  r = row;
        endcase
        return r;
    endfunction

    function automatic logic [ROW_W-1:0] lane_mask(input logic [3:0] sel,
                                                  input logic [2:0] width);
        logic [ROW_W-1:0] m;
        case (width)
            WIDTH_X1: m = view_to_row(16'h0001 << sel);
            WIDTH_X2: m = view_to_row(16'h0003 << {sel[3:1], 1'b0});
            WIDTH_X4: m = view_to_row(16'h000F << {sel[3:2], 2'b00});
            WIDTH_X9: m = sel[3] ? 18'h3FE00 : 18'h001FF;
            default:  m = '1;
        endcase
        return m;
    endfunction

    function automatic logic [ROW_W-1:0] lane_data(input logic [ROW_W-1:0] din,
                                                  input logic [3:0] sel,
                                                  input logic [2:0] width);
        logic [ROW_W-1:0] d;
        case (width)
            WIDTH_X1: d = view_to_row({15'b0, din[0]} << sel);
            WIDTH_X2: d = view_to_row({14'b0, din[1:0]} << {sel[3:1], 1'b0});
            WIDTH_X4: d = view_to_row({12'b0, din[3:0]} << {sel[3:2], 2'b00});
            WIDTH_X9: d = sel[3] ? {din[8:0], 9'b0} : {9'b0, din[8:0]};
            default:  d = din;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/ram64x18_rd_port.sv
// One read port: optional address register, lane select and optional output register.
module ram64x18_rd_port
    import ram64x18_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [9:0]       addr_i,
    input  logic [1:0]       blk_i,
    input  logic             en_i,
    input  logic             addr_en_i,
    input  logic             dout_en_i,
    input  logic             addr_srst_ni,
    input  logic             dout_srst_ni,
    input  logic             addr_lat_i,
    input  logic             dout_lat_i,
    input  logic [2:0]       width_i,
    output logic [5:0]       row_idx_o,
    input  logic [ROW_W-1:0] row_data_i,
    output logic [ROW_W-1:0] dout_o
);

    logic [9:0]       addr_q, addr_d, eff_addr;
    logic [1:0]       blk_q, blk_d, eff_blk;
    logic [ROW_W-1:0] dout_q, dout_d, rd_data;

    always_comb begin
        addr_d = addr_q;
        blk_d  = blk_q;
        if (!addr_srst_ni) begin
            addr_d = '0;
            blk_d  = '0;
        end else if (addr_en_i) begin
            addr_d = addr_i;
            blk_d  = blk_i;
        end
    end

    always_comb begin
        eff_addr  = addr_lat_i ? addr_i : addr_q;
        eff_blk   = addr_lat_i ? blk_i : blk_q;
        row_idx_o = eff_addr[9:4];
        rd_data   = '0;
        if (en_i && eff_blk == 2'b11) begin
            rd_data = lane_read(row_data_i, eff_addr[3:0], width_i);
        end
    end

    always_comb begin
        dout_d = dout_q;
        if (!dout_srst_ni) begin
            dout_d = '0;
        end else if (dout_en_i) begin
            dout_d = rd_data;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            addr_q <= '0;
            blk_q  <= '0;
            dout_q <= '0;
        end else begin
            addr_q <= addr_d;
            blk_q  <= blk_d;
            dout_q <= dout_d;
        end
    end

    // Held reset forces zero even on the flow-through path.
    always_comb begin
        dout_o = '0;
        if (rst_ni) begin
            dout_o = dout_lat_i ? rd_data : dout_q;
        end
    end

endmodule

// File: rtl/ram64x18.sv
// 64x18 two-read, one-write RAM with per-port width modes and optional pipelining.
module ram64x18
    import ram64x18_pkg::*;
(
    input  logic        CLK,
    input  logic        ARST_N,
    input  logic [9:0]  A_ADDR,
    input  logic [9:0]  B_ADDR,
    input  logic [1:0]  A_BLK,
    input  logic [1:0]  B_BLK,
    input  logic [1:0]  C_BLK,
    input  logic        A_EN,
    input  logic        B_EN,
    input  logic        C_EN,
    input  logic        A_ADDR_EN,
    input  logic        B_ADDR_EN,
    input  logic        A_DOUT_EN,
    input  logic        B_DOUT_EN,
    input  logic        A_ADDR_SRST_N,
    input  logic        B_ADDR_SRST_N,
    input  logic        A_DOUT_SRST_N,
    input  logic        B_DOUT_SRST_N,
    input  logic        A_ADDR_LAT,
    input  logic        B_ADDR_LAT,
    input  logic        A_DOUT_LAT,
    input  logic        B_DOUT_LAT,
    input  logic [2:0]  A_WIDTH,
    input  logic [2:0]  B_WIDTH,
    input  logic [2:0]  C_WIDTH,
    input  logic [9:0]  C_ADDR,
    input  logic [17:0] C_DIN,
    input  logic        C_WEN,
    input  logic        SII_LOCK,
    output logic [17:0] A_DOUT,
    output logic [17:0] B_DOUT,
    output logic        BUSY
);

    logic [ROW_W-1:0] mem [ROWS];

    logic             wr_en;
    logic [5:0]       wr_row;
    logic [ROW_W-1:0] wr_mask, wr_data, mem_wdata;
    logic [5:0]       a_row, b_row;
    logic [ROW_W-1:0] a_row_data, b_row_data;
    logic             unused_sii_lock;

    assign unused_sii_lock = SII_LOCK;
    assign BUSY            = 1'b0;

    always_comb begin
        wr_en     = C_EN && (C_BLK == 2'b11) && C_WEN;
        wr_row    = C_ADDR[9:4];
        wr_mask   = lane_mask(C_ADDR[3:0], C_WIDTH);
        wr_data   = lane_data(C_DIN, C_ADDR[3:0], C_WIDTH);
        mem_wdata = (mem[wr_row] & ~wr_mask) | (wr_data & wr_mask);
    end

    // Array has no reset; a low ARST_N at the edge suppresses the write.
    always_ff @(posedge CLK) begin
        if (wr_en && ARST_N) begin
            mem[wr_row] <= mem_wdata;
        end
    end

    assign a_row_data = mem[a_row];
    assign b_row_data = mem[b_row];

    ram64x18_rd_port u_port_a (
        .clk_i        (CLK),
        .rst_ni       (ARST_N),
        .addr_i       (A_ADDR),
        .blk_i        (A_BLK),
        .en_i         (A_EN),
        .addr_en_i    (A_ADDR_EN),
        .dout_en_i    (A_DOUT_EN),
        .addr_srst_ni (A_ADDR_SRST_N),
        .dout_srst_ni (A_DOUT_SRST_N),
        .addr_lat_i   (A_ADDR_LAT),
        .dout_lat_i   (A_DOUT_LAT),
        .width_i      (A_WIDTH),
        .row_idx_o    (a_row),
        .row_data_i   (a_row_data),
        .dout_o       (A_DOUT)
    );

    ram64x18_rd_port u_port_b (
        .clk_i        (CLK),
        .rst_ni       (ARST_N),
        .addr_i       (B_ADDR),
        .blk_i        (B_BLK),
        .en_i         (B_EN),
        .addr_en_i    (B_ADDR_EN),
        .dout_en_i    (B_DOUT_EN),
        .addr_srst_ni (B_ADDR_SRST_N),
        .dout_srst_ni (B_DOUT_SRST_N),
        .addr_lat_i   (B_ADDR_LAT),
        .dout_lat_i   (B_DOUT_LAT),
        .width_i      (B_WIDTH),
        .row_idx_o    (b_row),
        .row_data_i   (b_row_data),
        .dout_o       (B_DOUT)
    );

endmodule

// File: tb/tb_ram64x18.sv
// Directed self-checking bench for ram64x18: width modes, latency, collisions, reset.
module tb_ram64x18;
    import ram64x18_pkg::*;

    logic        CLK = 1'b0;
    logic        ARST_N;
    logic [9:0]  A_ADDR, B_ADDR, C_ADDR;
    logic [1:0]  A_BLK, B_BLK, C_BLK;
    logic        A_EN, B_EN, C_EN;
    logic        A_ADDR_EN, B_ADDR_EN, A_DOUT_EN, B_DOUT_EN;
    logic        A_ADDR_SRST_N, B_ADDR_SRST_N, A_DOUT_SRST_N, B_DOUT_SRST_N;
    logic        A_ADDR_LAT, B_ADDR_LAT, A_DOUT_LAT, B_DOUT_LAT;
    logic [2:0]  A_WIDTH, B_WIDTH, C_WIDTH;
    logic [17:0] C_DIN;
    logic        C_WEN, SII_LOCK;
    logic [17:0] A_DOUT, B_DOUT;
    logic        BUSY;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    ram64x18 dut (
        .CLK(CLK), .ARST_N(ARST_N),
        .A_ADDR(A_ADDR), .B_ADDR(B_ADDR),
        .A_BLK(A_BLK), .B_BLK(B_BLK), .C_BLK(C_BLK),
        .A_EN(A_EN), .B_EN(B_EN), .C_EN(C_EN),
        .A_ADDR_EN(A_ADDR_EN), .B_ADDR_EN(B_ADDR_EN),
        .A_DOUT_EN(A_DOUT_EN), .B_DOUT_EN(B_DOUT_EN),
        .A_ADDR_SRST_N(A_ADDR_SRST_N), .B_ADDR_SRST_N(B_ADDR_SRST_N),
        .A_DOUT_SRST_N(A_DOUT_SRST_N), .B_DOUT_SRST_N(B_DOUT_SRST_N),
        .A_ADDR_LAT(A_ADDR_LAT), .B_ADDR_LAT(B_ADDR_LAT),
        .A_DOUT_LAT(A_DOUT_LAT), .B_DOUT_LAT(B_DOUT_LAT),
        .A_WIDTH(A_WIDTH), .B_WIDTH(B_WIDTH), .C_WIDTH(C_WIDTH),
        .C_ADDR(C_ADDR), .C_DIN(C_DIN), .C_WEN(C_WEN),
        .SII_LOCK(SII_LOCK),
        .A_DOUT(A_DOUT), .B_DOUT(B_DOUT), .BUSY(BUSY)
    );

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [17:0] obs, input logic [17:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%05h expected=%05h", tag, obs, exp);
        end
    endtask

    initial begin
        ARST_N = 1'b1;
        A_ADDR = '0; B_ADDR = '0; C_ADDR = '0;
        A_BLK = 2'b11; B_BLK = 2'b11; C_BLK = 2'b11;
        A_EN = 1'b1; B_EN = 1'b1; C_EN = 1'b1;
        A_ADDR_EN = 1'b1; B_ADDR_EN = 1'b1; A_DOUT_EN = 1'b1; B_DOUT_EN = 1'b1;
        A_ADDR_SRST_N = 1'b1; B_ADDR_SRST_N = 1'b1;
        A_DOUT_SRST_N = 1'b1; B_DOUT_SRST_N = 1'b1;
        A_ADDR_LAT = 1'b0; A_DOUT_LAT = 1'b1;
        B_ADDR_LAT = 1'b1; B_DOUT_LAT = 1'b1;
        A_WIDTH = WIDTH_X9; B_WIDTH = WIDTH_X9; C_WIDTH = WIDTH_X9;
        C_DIN = '0; C_WEN = 1'b0; SII_LOCK = 1'b0;

        // Reset state
        #2 ARST_N = 1'b0;
        #1;
        check("reset_a_dout", A_DOUT, 18'h0);
        check("reset_b_dout", B_DOUT, 18'h0);
        check("reset_busy", {17'b0, BUSY}, 18'h0);
        step();
        step();
        ARST_N = 1'b1;

        // x9 write then registered-address read, data one cycle later
        C_ADDR = 10'd40; C_DIN = 18'h000A5; C_WEN = 1'b1;
        step();
        C_WEN = 1'b0;
        A_ADDR = 10'd40;
        step();
        check("x9_reg_addr_read", A_DOUT, 18'h000A5);

        // Write disabled leaves contents alone
        C_DIN = 18'h00055;
        step();
        check("wen_low_no_write", A_DOUT, 18'h000A5);

        // Collision: flow-through sees old before edge, both see new after
        B_ADDR = 10'd40;
        #1 check("ft_read_before", B_DOUT, 18'h000A5);
        C_DIN = 18'h001C3; C_WEN = 1'b1;
        #1 check("ft_collide_old", B_DOUT, 18'h000A5);
        step();
        C_WEN = 1'b0;
        check("ft_collide_new", B_DOUT, 18'h001C3);
        check("reg_collide_new", A_DOUT, 18'h001C3);

        // x9 fill and read back in order
        C_WEN = 1'b1;
        for (int i = 0; i < 128; i++) begin
            C_ADDR = 10'(i * 8);
            C_DIN = 18'(i);
            step();
        end
        C_WEN = 1'b0;
        for (int i = 0; i < 128; i++) begin
            A_ADDR = 10'(i * 8);
            step();
            check($sformatf("x9_fill_%0d", i), A_DOUT, 18'(i));
        end

        // x18 write, narrower reads of the same row
        C_WIDTH = WIDTH_X18; C_ADDR = 10'd160; C_DIN = 18'h3FFFF; C_WEN = 1'b1;
        step();
        C_ADDR = 10'd176; C_DIN = 18'h2A5C3;
        step();
        C_WEN = 1'b0;
        A_ADDR = 10'd160; step();
        check("x18_as_x9_lo", A_DOUT, 18'h001FF);
        A_ADDR = 10'd168; step();
        check("x18_as_x9_hi", A_DOUT, 18'h001FF);
        A_WIDTH = WIDTH_X1; A_ADDR = 10'd160; step();
        check("x18_as_x1_lane0", A_DOUT, 18'h00001);

        // Row 11 = 0x2A5C3, 16-bit view = 0x52C3
        B_WIDTH = WIDTH_X4; B_ADDR = 10'd188;
        #1 check("x4_lane3", B_DOUT, 18'h00005);
        B_WIDTH = WIDTH_X2; B_ADDR = 10'd182;
        #1 check("x2_lane3", B_DOUT, 18'h00003);
        B_WIDTH = WIDTH_X1; B_ADDR = 10'd185;
        #1 check("x1_lane9", B_DOUT, 18'h00001);
        B_WIDTH = WIDTH_X9; B_ADDR = 10'd184;
        #1 check("x9_hi_row11", B_DOUT, 18'h00152);

        // x4 write to lane 1 only; high C_DIN bits must be ignored
        C_WIDTH = WIDTH_X4; C_ADDR = 10'd180; C_DIN = 18'h3FFFA; C_WEN = 1'b1;
        step();
        C_WEN = 1'b0;
        B_WIDTH = WIDTH_X18; B_ADDR = 10'd176;
        #1 check("x4_partial_write", B_DOUT, 18'h2A5A3);

        // Deselection
        A_WIDTH = WIDTH_X9; A_ADDR = 10'd72; A_BLK = 2'b01;
        step();
        check("a_blk_01", A_DOUT, 18'h0);
        A_BLK = 2'b11;
        step();
        check("a_reselect", A_DOUT, 18'h00009);
        A_EN = 1'b0;
        #1 check("a_en_low", A_DOUT, 18'h0);
        A_EN = 1'b1;
        B_BLK = 2'b01;
        #1 check("b_blk_01_ft", B_DOUT, 18'h0);
        B_BLK = 2'b11;

        // Two-cycle latency with both registers
        A_DOUT_LAT = 1'b0;
        step();
        A_ADDR = 10'd24;
        step();
        check("lat2_first_edge", A_DOUT, 18'h00009);
        step();
        check("lat2_second_edge", A_DOUT, 18'h00003);

        // Output hold, output clear, address clear
        A_DOUT_EN = 1'b0; A_ADDR = 10'd32;
        step(); step();
        check("dout_en_hold", A_DOUT, 18'h00003);
        A_DOUT_SRST_N = 1'b0;
        step();
        check("dout_srst", A_DOUT, 18'h0);
        A_DOUT_SRST_N = 1'b1; A_DOUT_EN = 1'b1; A_DOUT_LAT = 1'b1;
        step();
        check("addr_reload", A_DOUT, 18'h00004);
        A_ADDR_SRST_N = 1'b0;
        step();
        check("addr_srst_deselects", A_DOUT, 18'h0);
        A_ADDR_SRST_N = 1'b1;

        // Async reset with registered output, then re-read
        A_DOUT_LAT = 1'b0; A_ADDR = 10'd56;
        step(); step();
        check("pre_reset_value", A_DOUT, 18'h00007);
        ARST_N = 1'b0;
        #1 check("async_reset_a", A_DOUT, 18'h0);
        step();
        ARST_N = 1'b1;
        step(); step();
        check("post_reset_reread", A_DOUT, 18'h00007);

        // Reset at the write edge blocks the write
        C_WIDTH = WIDTH_X9; C_ADDR = 10'd56; C_DIN = 18'h001EE; C_WEN = 1'b1;
        ARST_N = 1'b0;
        step();
        ARST_N = 1'b1; C_WEN = 1'b0;
        B_WIDTH = WIDTH_X9; B_ADDR = 10'd56;
        #1 check("reset_blocks_write", B_DOUT, 18'h00007);
        check("busy_end", {17'b0, BUSY}, 18'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ram64x18.md
RAM64X18 -- requirements
Module: ram64x18

Interface
REQ-001 Parameters: none; the storage geometry is fixed at 64 rows x 18 bits, 1152 bits in total.
REQ-002 CLK  input  1  single clock; rising edge for all sampling.
REQ-003 ARST_N  input  1  reset, asynchronous and active-low.
REQ-004 A_ADDR, B_ADDR  input  10  read addresses, ports A and B.
REQ-005 A_BLK, B_BLK, C_BLK  input  2 each  block selects; a port is selected only when its BLK is 2'b11.
REQ-006 A_EN, B_EN, C_EN  input  1 each  port enables.
REQ-007 A_ADDR_EN, B_ADDR_EN  input  1 each  read-address register load enables.
REQ-008 A_DOUT_EN, B_DOUT_EN  input  1 each  output register load enables.
REQ-009 A_ADDR_SRST_N, B_ADDR_SRST_N, A_DOUT_SRST_N, B_DOUT_SRST_N  input  1 each  synchronous clears, active-low.
REQ-010 A_ADDR_LAT, B_ADDR_LAT  input  1 each  1 = address flow-through, 0 = address registered.
REQ-011 A_DOUT_LAT, B_DOUT_LAT  input  1 each  1 = data flow-through, 0 = data registered.
REQ-012 A_WIDTH, B_WIDTH, C_WIDTH  input  3 each  width codes: 000 x1, 001 x2, 010 x4, 011 x9, 100 x18; 101-111 = x18.
REQ-013 C_ADDR  input  10  write address; C_DIN  input  18  write data; C_WEN  input  1  write enable, active-high.
REQ-014 SII_LOCK  input  1  ignored.
REQ-015 A_DOUT, B_DOUT  output  18 each  read data; BUSY  output  1  tied to 0.

Function
REQ-016 Row = ADDR[9:4].
REQ-017 x18 uses the whole row.
REQ-018 x9 uses row[8:0] when ADDR[3]=0 and row[17:9] when ADDR[3]=1.
REQ-019 x1/x2/x4 index the 16-bit view {row[16:9],row[7:0]}, using ADDR[3:0], ADDR[3:1] and ADDR[3:2] respectively as the lane index.
REQ-020 Write fires on a CLK rise when C_EN=1, C_BLK=2'b11 and C_WEN=1.
REQ-021 A write updates only the selected lane, taking its data from the low bits of C_DIN.
REQ-022 The read-address register loads {ADDR,BLK} on a CLK rise when ADDR_EN=1; ADDR_SRST_N=0 loads zero instead, with priority over the load.
REQ-023 With ADDR_LAT=1 the raw inputs bypass the read-address register.
REQ-024 Array read is combinational from the effective address; the lane is right-justified in DOUT and unused upper bits are 0.
REQ-025 DOUT is 0 when the port is deselected: EN=0 or effective BLK != 2'b11.
REQ-026 DOUT_LAT=1: DOUT follows the read data combinationally.
REQ-027 DOUT_LAT=0: DOUT is registered and loads on a CLK rise when DOUT_EN=1; DOUT_SRST_N=0 clears it synchronously.
REQ-028 Latency: one cycle from address to data with ADDR_LAT=0/DOUT_LAT=1, two cycles with both registered, zero with both flow-through.
REQ-029 Write/read collision on the same lane: a registered read address sees the new data from the cycle after the write edge; a flow-through read address sees the old data before the edge and the new data after it.
REQ-030 Ports A and B are independent; both may read the same address in the same cycle.
REQ-031 x9 boundary: address {7'd127,3'b0} maps to row 63 bits [17:9] and is valid; no address wraps or faults.

Reset
REQ-032 ARST_N=0 clears both read-address registers and both output registers to 0 immediately; A_DOUT and B_DOUT read 0 while reset is held.
REQ-033 Reset does not alter array contents; contents are undefined until written.
REQ-034 A reset asserted mid-write on the same edge blocks that write.

Structure
REQ-035 Package ram64x18_pkg holds the width-code constants, ROWS=64 and ROW_W=18.
REQ-036 One sub-module, ram64x18_rd_port, contains the address register, lane select and output register; it is instantiated twice, for A and B.

Verification
REQ-037 x9 write, registered address, flow-through data (ADDR_LAT=0, DOUT_LAT=1), A_EN=1, A_BLK=11: C_DIN=0x0A5 at C_ADDR={7'd5,3'b0}, then A_ADDR=same -> A_DOUT=0x0A5 one cycle later.
REQ-038 x9 fill 128 addresses with value=index, read back in order -> each DOUT equals its index; address 127 returns 0x07F.
REQ-039 x18 write 0x3FFFF at row 10, then x9 reads of {7'd20,3'b0} and {7'd21,3'b0} -> 0x1FF and 0x1FF; x1 read of lane 0 -> 0x00001.
REQ-040 C_WEN=0 with C_DIN=0x055 at a location holding 0x0A5 -> read still returns 0x0A5.
REQ-041 ARST_N pulsed low with DOUT_LAT=0 -> A_DOUT=0 at once; after release, a re-read returns the stored data unchanged.
REQ-042 A_BLK=2'b01 -> A_DOUT=0; BUSY=0 in every scenario.
